// File: rtl/aes_pkg.sv
// +------------------------------------------------------------------------+
// | aes_pkg : shared AES decryption datapath types and constants           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;
    typedef logic [3:0]   round_t;

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        READY = 1'b1
    } ark_key_state_e;

endpackage

`default_nettype wire

// File: rtl/inv_add_round_key_if.sv
// +------------------------------------------------------------------------+
// | inv_add_round_key_if : key-load, upstream and downstream bus bundle    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

interface inv_add_round_key_if;
    import aes_pkg::*;

    logic   key_valid;
    word_t  key_word;
    logic   key_ready;
    logic   key_reload;
    logic   key_loaded;
    logic   in_valid;
    logic   in_ready;
    block_t data_in;
    logic   out_valid;
    logic   out_ready;
    block_t data_out;
    round_t round_out;
    logic   mix_en;
    logic   last;

    modport master (
        output key_valid, key_word, key_reload, in_valid, data_in, out_ready,
        input  key_ready, key_loaded, in_ready, out_valid, data_out, round_out, mix_en, last
    );

    modport slave (
        input  key_valid, key_word, key_reload, in_valid, data_in, out_ready,
        output key_ready, key_loaded, in_ready, out_valid, data_out, round_out, mix_en, last
    );

endinterface

`default_nettype wire

// File: rtl/round_key_store.sv
// +------------------------------------------------------------------------+
// | round_key_store : (NR+1) x 128-bit round-key file, 32-bit word write,  |
// | 128-bit combinational read. Option: INV_ARK_KEY_ZEROIZE_EN             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module round_key_store
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_i,
    input  logic                             we_i,
    input  logic [$clog2(4*(NR+1))-1:0]      waddr_i,
    input  word_t                            wdata_i,
    input  round_t                           raddr_i,
    output block_t                           rdata_o
);

    localparam int WIDX_W = $clog2(4 * (NR + 1));
    localparam int ROW_W  = WIDX_W - 2;

    block_t           rk_q [NR+1];
    logic [ROW_W-1:0] w_row;
    logic [1:0]       w_col;

    // Word i lands in round key i/4, column i%4 (column c at bits [32c+:32]).
    assign w_row = waddr_i[WIDX_W-1:2];
    assign w_col = waddr_i[1:0];

`ifdef INV_ARK_KEY_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int r = 0; r <= NR; r++) begin
                rk_q[r] <= '0;
            end
        end else if (we_i) begin
            rk_q[w_row][{w_col, 5'b0} +: 32] <= wdata_i;
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = rst ^ clear_i;

    always_ff @(posedge clk) begin
        if (we_i) begin
            rk_q[w_row][{w_col, 5'b0} +: 32] <= wdata_i;
        end
    end
`endif

    assign rdata_o = rk_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/inv_add_round_key.sv
// +------------------------------------------------------------------------+
// | inv_add_round_key : AES inverse AddRoundKey register slice with round  |
// | counter (NR..0) and serial round-key load port.                        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module inv_add_round_key
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic               clk,
    input  logic               rst,
    inv_add_round_key_if.slave bus
);

    localparam int                WORDS       = 4 * (NR + 1);
    localparam int                WIDX_W      = $clog2(WORDS);
    localparam logic [0:0]        ST_LOAD     = LOAD;
    localparam logic [0:0]        ST_READY    = READY;
    localparam logic [WIDX_W-1:0] C_LAST_WORD = WIDX_W'(WORDS - 1);
    localparam round_t            C_NR        = round_t'(NR);

    logic [0:0]        key_state_q, key_state_d;
    logic [WIDX_W-1:0] wcnt_q, wcnt_d;
    round_t            rnd_q, rnd_d;
    logic              out_valid_q, out_valid_d;
    block_t            data_q, data_d;
    round_t            round_q, round_d;
    logic              mix_q, mix_d;
    logic              last_q, last_d;

    logic   w_key_ready;
    logic   w_key_loaded;
    logic   w_reload_grant;
    logic   w_key_we;
    logic   w_in_ready;
    logic   w_accept;
    block_t w_rk;

    assign w_key_ready    = (key_state_q == ST_LOAD);
    assign w_key_loaded   = (key_state_q == ST_READY);
    // Reload only between blocks: nothing in flight and counter parked at NR.
    assign w_reload_grant = bus.key_reload && !out_valid_q && (rnd_q == C_NR);
    assign w_key_we       = bus.key_valid && w_key_ready && !w_reload_grant && !rst;
    assign w_in_ready     = w_key_loaded && (!out_valid_q || bus.out_ready);
    assign w_accept       = bus.in_valid && w_in_ready;

    round_key_store #(
        .NR (NR)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_reload_grant),
        .we_i    (w_key_we),
        .waddr_i (wcnt_q),
        .wdata_i (bus.key_word),
        .raddr_i (rnd_q),
        .rdata_o (w_rk)
    );

    always_comb begin
        key_state_d = key_state_q;
        wcnt_d      = wcnt_q;
        if (w_reload_grant) begin
            key_state_d = ST_LOAD;
            wcnt_d      = '0;
        end else if (w_key_we) begin
            if (wcnt_q == C_LAST_WORD) begin
                key_state_d = ST_READY;
                wcnt_d      = '0;
            end else begin
                wcnt_d = wcnt_q + WIDX_W'(1);
            end
        end
    end

    always_comb begin
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        round_d     = round_q;
        mix_d       = mix_q;
        last_d      = last_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            data_d      = bus.data_in ^ w_rk;
            round_d     = rnd_q;
            mix_d       = (rnd_q != '0) && (rnd_q != C_NR);
            last_d      = (rnd_q == '0);
            rnd_d       = (rnd_q == '0) ? C_NR : rnd_q - round_t'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state_q <= ST_LOAD;
            wcnt_q      <= '0;
            rnd_q       <= C_NR;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            round_q     <= '0;
            mix_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            wcnt_q      <= wcnt_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            round_q     <= round_d;
            mix_q       <= mix_d;
            last_q      <= last_d;
        end
    end

    assign bus.key_ready  = w_key_ready;
    assign bus.key_loaded = w_key_loaded;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.round_out  = round_q;
    assign bus.mix_en     = mix_q;
    assign bus.last       = last_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
// +------------------------------------------------------------------------+
// | tb_inv_add_round_key : directed bench using the FIPS-197 C.1 vectors   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_inv_add_round_key;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [127:0] rk_tbl [11];
    logic [127:0] in_tbl [11];

    inv_add_round_key_if bif ();

    inv_add_round_key #(
        .NR (10)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS byte strings list column 0 first; the bus carries column 0 in bits [31:0].
    function automatic logic [127:0] pack(input logic [127:0] f);
        return {f[31:0], f[63:32], f[95:64], f[127:96]};
    endfunction

    task automatic run_pass(input logic [127:0] fips_in);
        bif.in_valid = 1'b1;
        bif.data_in  = pack(fips_in);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic load_keys();
        logic [127:0] t;
        for (int i = 0; i < 44; i++) begin
            t = rk_tbl[i / 4];
            bif.key_valid = 1'b1;
            bif.key_word  = t[127 - 32 * (i % 4) -: 32];
            @(posedge clk); #1;
        end
        bif.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
        checks++; if (bif.data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", bif.data_out); end
        checks++; if (bif.round_out !== 4'd0) begin errors++; $display("FAIL reset_round_out: got %0d want 0", bif.round_out); end
        checks++; if (bif.mix_en !== 1'b0 || bif.last !== 1'b0) begin errors++; $display("FAIL reset_flags: got mix=%b last=%b want 0 0", bif.mix_en, bif.last); end
        checks++; if (bif.key_ready !== 1'b1 || bif.key_loaded !== 1'b0) begin errors++; $display("FAIL reset_key: got ready=%b loaded=%b want 1 0", bif.key_ready, bif.key_loaded); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bif.in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_key_load();
        logic [127:0] t;
        for (int i = 0; i < 44; i++) begin
            t = rk_tbl[i / 4];
            bif.key_valid = 1'b1;
            bif.key_word  = t[127 - 32 * (i % 4) -: 32];
            if (i == 43) begin
                checks++; if (bif.key_loaded !== 1'b0 || bif.in_ready !== 1'b0) begin errors++; $display("FAIL load_early: got loaded=%b in_ready=%b want 0 0", bif.key_loaded, bif.in_ready); end
            end
            @(posedge clk); #1;
        end
        bif.key_valid = 1'b0;
        checks++; if (bif.key_loaded !== 1'b1 || bif.key_ready !== 1'b0) begin errors++; $display("FAIL load_done: got loaded=%b ready=%b want 1 0", bif.key_loaded, bif.key_ready); end
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready: got %b want 1", bif.in_ready); end
    endtask

    task automatic test_stream();
        logic [127:0] exp;
        for (int k = 0; k <= 10; k++) begin
            checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, bif.in_ready); end
            bif.in_valid = 1'b1;
            bif.data_in  = pack(in_tbl[k]);
            @(posedge clk); #1;
            exp = pack(in_tbl[k] ^ rk_tbl[10 - k]);
            checks++; if (bif.data_out !== exp) begin errors++; $display("FAIL stream_data k=%0d: got %h want %h", k, bif.data_out, exp); end
            checks++; if (bif.round_out !== 4'(10 - k)) begin errors++; $display("FAIL stream_round k=%0d: got %0d want %0d", k, bif.round_out, 10 - k); end
            checks++; if (bif.mix_en !== 1'(k != 0 && k != 10)) begin errors++; $display("FAIL stream_mix k=%0d: got %b", k, bif.mix_en); end
            checks++; if (bif.last !== 1'(k == 10)) begin errors++; $display("FAIL stream_last k=%0d: got %b", k, bif.last); end
            checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b want 1", k, bif.out_valid); end
            if (k == 0) begin
                checks++; if (bif.data_out !== pack(128'h7ad5fda789ef4e272bca100b3d9ff59f)) begin errors++; $display("FAIL first_pass_vector: got %h", bif.data_out); end
            end
            if (k == 10) begin
                checks++; if (bif.data_out !== pack(128'h00112233445566778899aabbccddeeff)) begin errors++; $display("FAIL plaintext_vector: got %h", bif.data_out); end
            end
        end
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b want 0", bif.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        exp_a = pack(in_tbl[0] ^ rk_tbl[10]);
        exp_b = pack(in_tbl[1] ^ rk_tbl[9]);
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b1;
        bif.data_in   = pack(in_tbl[0]);
        @(posedge clk); #1;
        bif.data_in = pack(in_tbl[1]);
        for (int c = 0; c < 5; c++) begin
            checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, bif.in_ready); end
            checks++; if (bif.data_out !== exp_a || bif.out_valid !== 1'b1 || bif.round_out !== 4'd10) begin errors++; $display("FAIL bp_hold c=%0d: got %h v=%b r=%0d want %h 1 10", c, bif.data_out, bif.out_valid, bif.round_out, exp_a); end
            @(posedge clk); #1;
        end
        bif.out_ready = 1'b1;
        #1;
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bif.in_ready); end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        checks++; if (bif.data_out !== exp_b || bif.round_out !== 4'd9 || bif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_next: got %h r=%0d v=%b want %h 9 1", bif.data_out, bif.round_out, bif.out_valid, exp_b); end
        @(posedge clk); #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bif.out_valid); end
    endtask

    task automatic test_reload_ignored();
        run_pass(in_tbl[2]);            // round 8 applied, counter now 7
        @(posedge clk); #1;
        bif.key_reload = 1'b1;
        @(posedge clk); #1;
        bif.key_reload = 1'b0;
        checks++; if (bif.key_loaded !== 1'b1 || bif.key_ready !== 1'b0) begin errors++; $display("FAIL reload_ignored: got loaded=%b ready=%b want 1 0", bif.key_loaded, bif.key_ready); end
        run_pass(in_tbl[3]);
        checks++; if (bif.round_out !== 4'd7 || bif.data_out !== pack(in_tbl[3] ^ rk_tbl[7])) begin errors++; $display("FAIL reload_ignored_round: got r=%0d d=%h want 7", bif.round_out, bif.data_out); end
        for (int k = 4; k <= 10; k++) run_pass(in_tbl[k]);
        @(posedge clk); #1;
    endtask

    task automatic test_reload_granted();
        bif.key_reload = 1'b1;
        @(posedge clk); #1;
        bif.key_reload = 1'b0;
        checks++; if (bif.key_loaded !== 1'b0 || bif.key_ready !== 1'b1 || bif.in_ready !== 1'b0) begin errors++; $display("FAIL reload_granted: got loaded=%b ready=%b in_ready=%b want 0 1 0", bif.key_loaded, bif.key_ready, bif.in_ready); end
`ifdef INV_ARK_KEY_ZEROIZE_EN
        checks++; if (u_dut.u_store.rk_q[0] !== 128'h0) begin errors++; $display("FAIL zeroize_rk0: got %h want 0", u_dut.u_store.rk_q[0]); end
`endif
        load_keys();
        checks++; if (bif.key_loaded !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", bif.key_loaded); end
        run_pass(in_tbl[0]);
        checks++; if (bif.round_out !== 4'd10 || bif.data_out !== pack(128'h7ad5fda789ef4e272bca100b3d9ff59f)) begin errors++; $display("FAIL reload_pass: got r=%0d d=%h", bif.round_out, bif.data_out); end
    endtask

    task automatic test_reset_midblock();
        for (int k = 1; k <= 6; k++) run_pass(in_tbl[k]);   // rounds 9..4
        checks++; if (bif.round_out !== 4'd4 || bif.out_valid !== 1'b1) begin errors++; $display("FAIL mid_round4: got r=%0d v=%b want 4 1", bif.round_out, bif.out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bif.out_valid !== 1'b0 || bif.key_loaded !== 1'b0 || bif.key_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got v=%b loaded=%b ready=%b want 0 0 1", bif.out_valid, bif.key_loaded, bif.key_ready); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 0", bif.in_ready); end
        load_keys();
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reload_ready: got %b want 1", bif.in_ready); end
        run_pass(in_tbl[0]);
        checks++; if (bif.round_out !== 4'd10 || bif.data_out !== pack(128'h7ad5fda789ef4e272bca100b3d9ff59f)) begin errors++; $display("FAIL mid_counter_nr: got r=%0d d=%h want 10", bif.round_out, bif.data_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rk_tbl[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tbl[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tbl[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tbl[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tbl[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tbl[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tbl[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tbl[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tbl[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tbl[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tbl[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        in_tbl[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_tbl[1]  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        in_tbl[2]  = 128'hfde3bad205e5d0d73547964ef1fe37f1;
        in_tbl[3]  = 128'hd1876c0f79c4300ab45594add66ff41f;
        in_tbl[4]  = 128'hc62fe109f75eedc3cc79395d84f9cf5d;
        in_tbl[5]  = 128'hc81677bc9b7ac93b25027992b0261996;
        in_tbl[6]  = 128'h247240236966b3fa6ed2753288425b6c;
        in_tbl[7]  = 128'hfa636a2825b339c940668a3157244d17;
        in_tbl[8]  = 128'h4915598f55e5d7a0daca94fa1f0a63f7;
        in_tbl[9]  = 128'h8960494b9049fceabf456751cab7a28e;
        in_tbl[10] = 128'h00102030405060708090a0b0c0d0e0f0;
        bif.key_valid  = 1'b0;
        bif.key_word   = '0;
        bif.key_reload = 1'b0;
        bif.in_valid   = 1'b0;
        bif.data_in    = '0;
        bif.out_ready  = 1'b1;

        test_reset();
        test_key_load();
        test_stream();
        test_backpressure();
        test_reload_ignored();
        test_reload_granted();
        test_reset_midblock();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
